uart_rx: RTL
============

# uart_rx

UART receiver that recovers 8-bit characters from the asynchronous serial line driven by the team's UART transmitter, or by any external device using the same framing. Framing is 1 start bit, 8 data bits LSB first, an optional parity bit, and 1 stop bit. The block oversamples the line using an externally generated tick and majority-free mid-bit sampling. It presents each received byte with a one-cycle valid strobe plus parity and framing error flags. It sits between the pad-side `rx` pin and the host/FIFO that consumes received bytes.

## Interface
- `OS_RATE`, default 16: `os_tick` pulses per bit period. Must be an even number ≥ 4.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `os_tick` in 1: oversample strobe at `OS_RATE` × baud. Single-cycle pulse.
- `rx` in 1: serial line, asynchronous to `clk`. Idles high.
- `par_en` in 1: 1 means a parity bit is present after the data bits.
- `par_ty` in 1: 1 means even parity (expected bit = ^data); 0 means odd parity (expected bit = ~^data).
- `rx_data` out 8: last received byte.
- `rx_valid` out 1: one-`clk` pulse when a frame completes.
- `par_err` out 1: parity mismatch for the frame reported by the latest `rx_valid`.
- `frm_err` out 1: stop bit sampled low for the frame reported by the latest `rx_valid`.
- `rx_busy` out 1: high from start-bit detection until frame end.

## Operation
- **Synchronizer:** `rx` passes through 2 flops, which reset to 1, giving `rx_s`. A third flop `rx_d` holds the previous `rx_s` for edge detection. All decisions use `rx_s`.
- **Counters:**
  - Tick counter `tcnt`, width clog2(`OS_RATE`), advances only on `os_tick`.
  - Bit counter `bcnt`, 3 bits.
- **State machine** (IDLE, START, DATA, PARITY, STOP). Reset state is IDLE.
  - IDLE: on `rx_d`=1 and `rx_s`=0 (falling edge), clear `tcnt`, set `rx_busy`=1, go to START.
  - START: on `os_tick`, when `tcnt`=`OS_RATE`/2−1, sample `rx_s`. This is the bit centre.
    - If `rx_s`=1: false start. Clear `rx_busy`, go to IDLE. No `rx_valid`.
    - If `rx_s`=0: latch `par_en`/`par_ty` into internal copies, clear `tcnt` and `bcnt`, go to DATA.
  - DATA: on `os_tick`, when `tcnt`=`OS_RATE`−1, shift `rx_s` into the data register at the MSB, shifting right so the result is LSB first. Clear `tcnt`.
    - If `bcnt`=7, go to PARITY when latched `par_en`=1, otherwise go to STOP.
    - Otherwise `bcnt`+1.
  - PARITY: same sampling point as DATA. Store `rx_s` as the received parity bit, then go to STOP.
  - STOP: same sampling point. Then, on the same cycle:
    - `rx_data` <= shift register.
    - `frm_err` <= ~`rx_s`.
    - `par_err` <= (latched `par_en`) & (received parity ≠ expected parity, computed with the latched `par_ty`); otherwise 0.
    - `rx_valid` <= 1.
    - `rx_busy` <= 0.
    - Go to IDLE.
- A frame is always delivered even when an error flag is set. Error flags never suppress `rx_valid`.
- `rx_data`, `par_err`, and `frm_err` hold their values until the next `rx_valid`.
- Changes on `par_en`/`par_ty` mid-frame have no effect on the frame in progress.
- **Break / stuck-low line:** after a STOP with `frm_err`, IDLE re-arms only on a new falling edge. The line must return high first, so a held-low line yields exactly one frame with `frm_err`=1 and `rx_data`=0x00.
- An `os_tick` in IDLE is ignored. `os_tick` coincident with the falling edge does not advance `tcnt`.

## Timing
- **Reset values:**
  - `rx_data`=0x00, `rx_valid`=0, `par_err`=0, `frm_err`=0, `rx_busy`=0.
  - State IDLE, counters 0, sync flops 1.
- Reset asserted mid-frame aborts the frame immediately. There is no `rx_valid` for the partial frame.
- Edge-to-`rx_busy` latency: 3 `clk` from the `rx` pin (2 sync flops + state register).
- Start validation: `OS_RATE`/2 ticks after the edge is detected.
- Each subsequent sample is taken `OS_RATE` ticks after the previous one.
- `rx_valid` rises on the `clk` edge following the `os_tick` that samples the stop bit. It is high for exactly 1 `clk`.
- Data is first sampled roughly 1.5 bit periods after the falling edge. The stop bit is sampled 9.5 bit periods after the edge (10.5 with parity).
- Back-to-back frames: a start edge immediately following the stop-bit centre is accepted. There are no idle-bit requirements beyond the stop bit.
- Tolerates ±1 tick of edge-detect jitter, i.e. baud mismatch up to about 4% at `OS_RATE`=16.

## Test plan
- **Clean frame.** Setup: `OS_RATE`=16, `os_tick` every 4 clk, `par_en`=0. Stimulus: send 0xA5. Response: one `rx_valid` pulse, `rx_data`=0xA5, `par_err`=0, `frm_err`=0, `rx_busy` low after the pulse.
- **Parity.** Setup: `par_en`=1, `par_ty`=1.
  - Send 0x5A with parity bit 0. Response: `par_err`=0.
  - Resend 0x5A with parity bit 1. Response: `par_err`=1, `rx_data`=0x5A.
  - Set `par_ty`=0 with parity bit 1. Response: `par_err`=0.
- **Framing / break.** Stimulus: send 0x3C with stop bit 0. Response: `rx_valid`, `frm_err`=1, `rx_data`=0x3C. Stimulus: hold `rx` low for 20 bit periods. Response: exactly one `rx_valid` with `rx_data`=0x00, `frm_err`=1, and no further frames until `rx` returns high.
- **Glitch rejection.** Stimulus: drive `rx` low for 4 ticks, then high. Response: `rx_busy` pulses, then clears, and there is no `rx_valid`. A following valid 0x81 is received correctly.
- **Reset mid-frame.** Stimulus: assert `rst` during data bit 4 of 0xFF, release, then send 0x12. Response: no `rx_valid` for the partial frame, all outputs at reset values, then `rx_data`=0x12.
- **Loopback with the transmitter.** Stimulus: connect to `uart_tx` at a common baud (tx `baud_tick` every 16 `os_tick`). Send 0x00, 0xFF, and 0x55 back-to-back with `par_en`=1 and `par_ty`=0. Response: three `rx_valid` pulses with matching data, all error flags 0.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional parity, one stop bit.
// Samples mid-bit using an external oversample tick.
module uart_rx #(
  parameter int OS_RATE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       os_tick,
  input  logic       rx,
  input  logic       par_en,
  input  logic       par_ty,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       par_err,
  output logic       frm_err,
  output logic       rx_busy
);

  localparam int TW = $clog2(OS_RATE);
  localparam logic [TW-1:0] HALF = TW'(OS_RATE / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(OS_RATE - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t          state;
  logic            rx_m;
  logic            rx_s;
  logic            rx_d;
  logic [TW-1:0]   tcnt;
  logic [2:0]      bcnt;
  logic [7:0]      shreg;
  logic            pbit;
  logic            pen_l;
  logic            pty_l;
  logic            exp_par;
  logic            mid;

  // expected parity bit from the latched type and shifted data
  assign exp_par = pty_l ? ^shreg : ~^shreg;
  assign mid     = os_tick && (tcnt == FULL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m     <= 1'b1;
      rx_s     <= 1'b1;
      rx_d     <= 1'b1;
    end else begin
      rx_m     <= rx;
      rx_s     <= rx_m;
      rx_d     <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tcnt     <= '0;
      bcnt     <= '0;
      shreg    <= '0;
      pbit     <= 1'b0;
      pen_l    <= 1'b0;
      pty_l    <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
      rx_busy  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_d && !rx_s) begin
            tcnt    <= '0;
            rx_busy <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (os_tick) begin
            if (tcnt == HALF) begin
              if (rx_s) begin
                rx_busy <= 1'b0;
                state   <= IDLE;
              end else begin
                pen_l <= par_en;
                pty_l <= par_ty;
                tcnt  <= '0;
                bcnt  <= '0;
                state <= DATA;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (mid) begin
            shreg <= {rx_s, shreg[7:1]};
            tcnt  <= '0;
            if (bcnt == 3'd7)
              state <= pen_l ? PARITY : STOP;
            else
              bcnt <= bcnt + 1'b1;
          end else if (os_tick) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        PARITY: begin
          if (mid) begin
            pbit  <= rx_s;
            tcnt  <= '0;
            state <= STOP;
          end else if (os_tick) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        STOP: begin
          if (mid) begin
            rx_data  <= shreg;
            frm_err  <= ~rx_s;
            par_err  <= pen_l & (pbit != exp_par);
            rx_valid <= 1'b1;
            rx_busy  <= 1'b0;
            tcnt     <= '0;
            state    <= IDLE;
          end else if (os_tick) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
